// File: rtl/bus_check_monitor.sv
// rtl/bus_check_monitor.sv - programmable address/data bus check monitor with pass/fail/timeout verdict
module bus_check_monitor #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int NCHK       = 4,
    parameter int TO_W       = 20,
    parameter int EARLY_PASS = 0,
    localparam int IDX_W     = (NCHK > 1) ? $clog2(NCHK) : 1
) (
    input  logic              ph2,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic              cfg_en,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [TO_W-1:0]   timeout_limit,
    input  logic              start,
    input  logic              halt,
    input  logic              bus_valid,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timed_out,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [NCHK-1:0]   sat_vec,
    output logic [TO_W-1:0]   cycle_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state_q, state_d;

    logic [NCHK-1:0]              en_q, en_d, seen_q, seen_d;
    logic [NCHK-1:0][ADDR_W-1:0]  addr_q, addr_d;
    logic [NCHK-1:0][DATA_W-1:0]  exp_q, exp_d, last_q, last_d;

    logic              pass_q, timed_out_q;
    logic [IDX_W-1:0]  fail_idx_q;
    logic [TO_W-1:0]   cycle_count_q;

    logic [NCHK-1:0]   sat_now;
    logic              any_en, all_sat, to_hit;
    logic [IDX_W-1:0]  first_fail;
    logic              finish, pass_v, to_v;
    logic [IDX_W-1:0]  idx_v;

    // Entry update: config writes outside RUN, bus snooping inside RUN.
    always_comb begin
        en_d   = en_q;
        addr_d = addr_q;
        exp_d  = exp_q;
        seen_d = seen_q;
        last_d = last_q;
        for (int i = 0; i < NCHK; i++) begin
            if (state_q == S_RUN) begin
                if (bus_valid && bus_we && en_q[i] && (addr_q[i] == bus_addr)) begin
                    seen_d[i] = 1'b1;
                    last_d[i] = bus_data;
                end
            end else begin
                if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                    en_d[i]   = cfg_en;
                    addr_d[i] = cfg_addr;
                    exp_d[i]  = cfg_data;
                end
                if (start) begin
                    seen_d[i] = 1'b0;
                    last_d[i] = '0;
                end
            end
        end
    end

    // Verdict sees this cycle's write so a write coinciding with halt counts.
    always_comb begin
        sat_now    = '0;
        first_fail = '0;
        for (int i = 0; i < NCHK; i++)
            sat_now[i] = en_q[i] & seen_d[i] & (last_d[i] == exp_q[i]);
        for (int i = NCHK - 1; i >= 0; i--)
            if (en_q[i] && !sat_now[i])
                first_fail = IDX_W'(i);
        any_en  = |en_q;
        all_sat = any_en && (&(sat_now | ~en_q));
        to_hit  = (timeout_limit != '0) && (cycle_count_q == timeout_limit - TO_W'(1));
    end

    always_comb begin
        finish = 1'b0;
        pass_v = 1'b0;
        to_v   = 1'b0;
        idx_v  = '0;
        if (state_q == S_RUN) begin
            if (halt) begin
                finish = 1'b1;
                pass_v = all_sat;
            end else if ((EARLY_PASS != 0) && all_sat) begin
                finish = 1'b1;
                pass_v = 1'b1;
            end else if (to_hit) begin
                finish = 1'b1;
                to_v   = 1'b1;
            end
            idx_v = pass_v ? '0 : first_fail;
        end
    end

    always_ff @(posedge ph2 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)  state_d = S_RUN;
            S_RUN:   if (finish) state_d = S_DONE;
            S_DONE:  if (start)  state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    always_ff @(posedge ph2 or posedge reset) begin
        if (reset) begin
            en_q   <= '0;
            addr_q <= '0;
            exp_q  <= '0;
            seen_q <= '0;
            last_q <= '0;
        end else begin
            en_q   <= en_d;
            addr_q <= addr_d;
            exp_q  <= exp_d;
            seen_q <= seen_d;
            last_q <= last_d;
        end
    end

    // The finishing edge does not advance the counter.
    always_ff @(posedge ph2 or posedge reset) begin
        if (reset) begin
            pass_q        <= 1'b0;
            timed_out_q   <= 1'b0;
            fail_idx_q    <= '0;
            cycle_count_q <= '0;
        end else if ((state_q != S_RUN) && start) begin
            pass_q        <= 1'b0;
            timed_out_q   <= 1'b0;
            fail_idx_q    <= '0;
            cycle_count_q <= '0;
        end else if (finish) begin
            pass_q        <= pass_v;
            timed_out_q   <= to_v;
            fail_idx_q    <= idx_v;
        end else if ((state_q == S_RUN) && (cycle_count_q != '1)) begin
            cycle_count_q <= cycle_count_q + TO_W'(1);
        end
    end

    always_comb begin
        pass        = pass_q;
        timed_out   = timed_out_q;
        fail_idx    = fail_idx_q;
        cycle_count = cycle_count_q;
        for (int i = 0; i < NCHK; i++)
            sat_vec[i] = en_q[i] & seen_q[i] & (last_q[i] == exp_q[i]);
    end

endmodule

// File: tb/tb_bus_check_monitor.sv
// tb/tb_bus_check_monitor.sv - directed self-checking bench for bus_check_monitor
module tb_bus_check_monitor;

    logic        ph2 = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic        cfg_en = 1'b0;
    logic [15:0] cfg_addr = '0;
    logic [7:0]  cfg_data = '0;
    logic [19:0] timeout_limit = '0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        bus_valid = 1'b0;
    logic        bus_we = 1'b0;
    logic [15:0] bus_addr = '0;
    logic [7:0]  bus_data = '0;

    logic        busy, done, pass, timed_out;
    logic [1:0]  fail_idx;
    logic [3:0]  sat_vec;
    logic [19:0] cycle_count;

    logic        e_busy, e_done, e_pass, e_timed_out;
    logic [1:0]  e_fail_idx;
    logic [3:0]  e_sat_vec;
    logic [19:0] e_cycle_count;

    int errors = 0;
    int checks = 0;

    always #5 ph2 = ~ph2;

    bus_check_monitor #(.EARLY_PASS(0)) u_dut (
        .ph2(ph2), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .timeout_limit(timeout_limit),
        .start(start), .halt(halt), .bus_valid(bus_valid), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_data(bus_data), .busy(busy), .done(done), .pass(pass),
        .timed_out(timed_out), .fail_idx(fail_idx), .sat_vec(sat_vec), .cycle_count(cycle_count)
    );

    bus_check_monitor #(.EARLY_PASS(1)) u_early (
        .ph2(ph2), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .timeout_limit(timeout_limit),
        .start(start), .halt(halt), .bus_valid(bus_valid), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_data(bus_data), .busy(e_busy), .done(e_done), .pass(e_pass),
        .timed_out(e_timed_out), .fail_idx(e_fail_idx), .sat_vec(e_sat_vec), .cycle_count(e_cycle_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge ph2);
        #1;
    endtask

    task automatic cfg(input logic [1:0] idx, input logic en, input logic [15:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_halt();
        halt = 1'b1;
        tick();
        halt = 1'b0;
    endtask

    task automatic bus_cycle(input logic we, input logic [15:0] a, input logic [7:0] d);
        bus_valid = 1'b1; bus_we = we; bus_addr = a; bus_data = d;
        tick();
        bus_valid = 1'b0; bus_we = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_sat", sat_vec, 0);
        chk("rst_cc", cycle_count, 0);
        reset = 1'b0;
        tick();

        // single entry pass
        cfg(2'd0, 1'b1, 16'h022A, 8'h55);
        do_start();
        chk("t1_busy", busy, 1);
        bus_cycle(1'b1, 16'h022A, 8'h55);
        chk("t1_sat_live", sat_vec, 4'b0001);
        do_halt();
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        chk("t1_busy_off", busy, 0);
        chk("t1_sat", sat_vec, 4'b0001);
        chk("t1_fidx", fail_idx, 0);

        // three entries, middle one wrong
        cfg(2'd0, 1'b1, 16'h0010, 8'hAA);
        cfg(2'd1, 1'b1, 16'h0011, 8'hBB);
        cfg(2'd2, 1'b1, 16'h0012, 8'hCC);
        do_start();
        chk("t2_done_clr", done, 0);
        chk("t2_pass_clr", pass, 0);
        bus_cycle(1'b1, 16'h0010, 8'hAA);
        bus_cycle(1'b1, 16'h0011, 8'h00);
        bus_cycle(1'b1, 16'h0012, 8'hCC);
        do_halt();
        chk("t2_done", done, 1);
        chk("t2_pass", pass, 0);
        chk("t2_fidx", fail_idx, 1);
        chk("t2_sat", sat_vec, 4'b0101);
        chk("t2_to", timed_out, 0);

        // last write wins, reads ignored
        cfg(2'd1, 1'b0, 16'h0011, 8'hBB);
        cfg(2'd2, 1'b0, 16'h0012, 8'hCC);
        cfg(2'd0, 1'b1, 16'h0200, 8'h55);
        do_start();
        bus_cycle(1'b1, 16'h0200, 8'h55);
        chk("t3_sat_a", sat_vec, 4'b0001);
        bus_cycle(1'b1, 16'h0200, 8'h54);
        chk("t3_sat_b", sat_vec, 4'b0000);
        bus_cycle(1'b0, 16'h0200, 8'h55);
        do_halt();
        chk("t3_done", done, 1);
        chk("t3_pass", pass, 0);
        chk("t3_fidx", fail_idx, 0);
        chk("t3_sat", sat_vec, 4'b0000);

        // timeout at 100
        timeout_limit = 20'd100;
        do_start();
        repeat (99) tick();
        chk("t4_busy99", busy, 1);
        chk("t4_cc99", cycle_count, 99);
        tick();
        chk("t4_done", done, 1);
        chk("t4_to", timed_out, 1);
        chk("t4_pass", pass, 0);
        chk("t4_cc", cycle_count, 99);
        chk("t4_fidx", fail_idx, 0);

        // write plus halt on the timeout edge: halt wins
        do_start();
        repeat (99) tick();
        halt = 1'b1;
        bus_cycle(1'b1, 16'h0200, 8'h55);
        halt = 1'b0;
        chk("t4b_done", done, 1);
        chk("t4b_pass", pass, 1);
        chk("t4b_to", timed_out, 0);
        chk("t4b_sat", sat_vec, 4'b0001);

        // early pass; config write during RUN ignored
        timeout_limit = 20'd0;
        cfg(2'd0, 1'b1, 16'h0300, 8'h11);
        cfg(2'd1, 1'b1, 16'h0301, 8'h22);
        do_start();
        bus_cycle(1'b1, 16'h0300, 8'h11);
        cfg(2'd0, 1'b1, 16'h0300, 8'h99);
        repeat (4) tick();
        chk("t5_e_busy_pre", e_busy, 1);
        bus_cycle(1'b1, 16'h0301, 8'h22);
        chk("t5_e_done", e_done, 1);
        chk("t5_e_pass", e_pass, 1);
        chk("t5_e_busy", e_busy, 0);
        chk("t5_e_sat", e_sat_vec, 4'b0011);
        chk("t5_e_cc", e_cycle_count, 6);
        chk("t5_main_busy", busy, 1);
        chk("t5_main_sat", sat_vec, 4'b0011);
        do_halt();
        chk("t5_main_pass", pass, 1);
        chk("t5_e_done_hold", e_done, 1);

        // async reset mid-run, then run with nothing enabled
        do_start();
        bus_cycle(1'b1, 16'h0300, 8'h11);
        chk("t6_sat_pre", sat_vec, 4'b0001);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_sat", sat_vec, 0);
        chk("t6_cc", cycle_count, 0);
        tick();
        reset = 1'b0;
        tick();
        do_start();
        do_halt();
        chk("t6_done2", done, 1);
        chk("t6_pass2", pass, 0);
        chk("t6_fidx2", fail_idx, 0);
        chk("t6_e_pass2", e_pass, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
